decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, pipelined successor to the accumulator-machine instruction decoder.
- Sits between instruction fetch and the datapath/PC logic. Decodes one instruction per accepted beat into registered control and data fields for ACC_N accumulators.
- Adds valid/ready handshaking, a per-accumulator flag-hazard stall and a post-redirect flush counter.

Parameters:
- IW, 16, instruction width; opcode is always in[IW-1 -: 6].
- ACC_N, 2, accumulator count (2 or 4). AIW = clog2(ACC_N); accumulator index is in[IW-7 -: AIW].
- OPW_LO, IW-6-AIW (derived), width of the low operand field.
- HAZ_CYC, 2, cycles after an issued flag-writing op before its accumulator's flags are valid for a branch.
- FLUSH_CYC, 1, number of fetched instructions discarded after a taken jump/branch.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in  in  IW  instruction word
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts instruction
- flags  in  3*ACC_N  {z,c,n} per accumulator; accumulator k occupies [3k+2:3k]
- out_valid  out  1  decoded beat valid
- out_ready  in  1  downstream accepts
- acc_sel  out  2*ACC_N  per-accumulator source: 00 hold, 01 immediate, 10 ALU, 11 memory
- acc_idx  out  AIW  target accumulator
- wr_enable  out  1  memory write
- jmp_enable  out  1  unconditional jump
- branch_enable  out  1  taken branch
- illegal  out  1  undefined opcode, decoded as NOP
- op_code  out  6  opcode
- inm  out  8  in[7:0]
- mem_dir  out  OPW_LO  low operand field
- branch_dir  out  6  in[5:0]
- jmp_dir  out  OPW_LO  low operand field

Behaviour:
- Opcode map (class = op[5:3]):
  - 000000 NOP
  - 001000 LD: acc_sel[idx]=11
  - 001001 LDC: acc_sel[idx]=01
  - 001010 ST: wr_enable
  - 010xxx ALU (ADD, ADDC, SUB, SUBC, AND, ANDC, OR, ORC): acc_sel[idx]=10
  - 011000 ASL, 011001 ASR: acc_sel[idx]=10
  - 100000 JMP: jmp_enable
  - 101ccc branch on flags of acc idx: ccc = 000 EQ (z=1), 001 NE (z=0), 010 CS (c=1), 011 CC (c=0), 100 MI (n=1), 101 PL (n=0)
  - All other codes: illegal=1, all enables 0, acc_sel all 00.
- Flag writers: LD, LDC, classes 010 and 011.
- in_ready = (!out_valid || out_ready) && !stall.
- stall = in[15:13]==101 && in_valid && haz_cnt[idx] != 0 && drop_cnt == 0.
- Accept = in_valid && in_ready.
- On accept with drop_cnt == 0: the output register loads the decoded fields and out_valid=1 next cycle. Latency is 1 cycle.
- On accept with drop_cnt > 0: the instruction is discarded, drop_cnt decrements, and out_valid follows out_ready (it clears if the held beat is consumed).
- Output register holds all fields stable while out_valid && !out_ready. With no accept and out_ready=1, out_valid goes to 0.
- Branch condition is evaluated from flags at accept time and is registered in branch_enable.
- Taken branch or JMP on accept: drop_cnt <= FLUSH_CYC. Not-taken branch: no flush.
- haz_cnt[k]: loads HAZ_CYC when a flag writer to k is accepted (not dropped); otherwise decrements to 0 each cycle. Load wins over decrement.
- A flag writer and a branch on the same accumulator in back-to-back beats: the branch stalls HAZ_CYC cycles.
- Reset (wins over everything, including mid-stall and mid-flush): out_valid=0, all enables 0, acc_sel=0, illegal=0, data fields 0, drop_cnt=0, all haz_cnt=0.

Optional Feature:
- DECODE_PERF_CNT_EN defined: adds outputs stall_cnt (16) and drop_cnt_total (16), both reset to 0 and saturating at 0xFFFF.
  - stall_cnt increments each cycle stall=1.
  - drop_cnt_total increments per discarded instruction.
- Undefined: these ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset, then LDC idx0 in=0x2405, out_ready=1 -> next cycle out_valid=1, acc_sel=2'b01 on acc0, inm=0x05, all enables 0.
- Hold out_ready=0 after an ADD beat and present a second instruction -> in_ready=0; outputs unchanged for 5 cycles; the second instruction issues one cycle after out_ready=1.
- ADD acc1, then immediately BEQ acc1 with flags z1=1, HAZ_CYC=2 -> in_ready=0 for 2 cycles; then branch_enable=1 and branch_dir=in[5:0].
- JMP 0x3FF followed by two instructions with FLUSH_CYC=1 -> jmp_enable=1, jmp_dir=0x1FF (ACC_N=2); first follower dropped with no out_valid; second follower decoded.
- Opcode 111111 -> illegal=1, all enables 0, no flush, no hazard load.
- Assert reset while stalled and while drop_cnt=1 -> next cycle out_valid=0, in_ready=1, and the next branch is accepted without stall.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage - pipelined instruction decoder for an ACC_N-accumulator machine.
//
// This stage accepts one instruction per valid/ready beat. It registers the
// decoded control and data fields with a latency of one cycle. It stalls a
// branch while the flags of the accumulator it tests are still being produced
// by an earlier flag-writing instruction. After a taken jump or branch it
// discards the next FLUSH_CYC fetched instructions.
//
// Optional build macro: DECODE_PERF_CNT_EN adds two saturating 16-bit event
// counters, stall_cnt and drop_cnt_total.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   in / in_valid / in_ready     instruction word and its input handshake
//   flags           {z,c,n} per accumulator; accumulator k is at [3k+2:3k]
//   out_valid / out_ready        output handshake for the decoded beat
//   acc_sel         2 bits per accumulator: 00 hold, 01 imm, 10 ALU, 11 mem
//   acc_idx         target accumulator
//   wr_enable, jmp_enable, branch_enable, illegal   registered controls
//   op_code, inm, mem_dir, branch_dir, jmp_dir      registered data fields
//   stall_cnt, drop_cnt_total    (DECODE_PERF_CNT_EN only) event counters

module decode_stage #(
  parameter int  IW        = 16,
  parameter int  ACC_N     = 2,
  parameter int  HAZ_CYC   = 2,
  parameter int  FLUSH_CYC = 1,
  localparam int AIW       = $clog2(ACC_N),
  localparam int OPW_LO    = IW - 6 - AIW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IW-1:0]       in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*ACC_N-1:0]  flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*ACC_N-1:0]  acc_sel,
  output logic [AIW-1:0]      acc_idx,
  output logic                wr_enable,
  output logic                jmp_enable,
  output logic                branch_enable,
  output logic                illegal,
  output logic [5:0]          op_code,
  output logic [7:0]          inm,
  output logic [OPW_LO-1:0]   mem_dir,
  output logic [5:0]          branch_dir,
  output logic [OPW_LO-1:0]   jmp_dir
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         drop_cnt_total
`endif
);

  localparam int HW = (HAZ_CYC < 1) ? 1 : $clog2(HAZ_CYC + 1);
  localparam int DW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]     op;
  logic [AIW-1:0] idx;
  logic [2:0]     acc_flags [ACC_N];
  logic [2:0]     idx_flags;

  assign op  = in[IW-1 -: 6];
  assign idx = in[IW-7 -: AIW];

  for (genvar gi = 0; gi < ACC_N; gi++) begin : g_flags
    assign acc_flags[gi] = flags[3*gi+2 : 3*gi];
  end

  assign idx_flags = acc_flags[idx];

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [1:0]         dec_src;
  logic               dec_wr;
  logic               dec_jmp;
  logic               dec_br;
  logic               dec_illegal;
  logic               dec_flag_wr;
  logic               br_cond;
  logic               dec_taken;
  logic [2*ACC_N-1:0] dec_acc_sel;

  always_comb begin
    dec_src     = 2'b00;
    dec_wr      = 1'b0;
    dec_jmp     = 1'b0;
    dec_br      = 1'b0;
    dec_illegal = 1'b0;
    dec_flag_wr = 1'b0;
    casez (op)
      6'b000000: ;                                                  // NOP
      6'b001000: begin dec_src = 2'b11; dec_flag_wr = 1'b1; end     // LD
      6'b001001: begin dec_src = 2'b01; dec_flag_wr = 1'b1; end     // LDC
      6'b001010: dec_wr = 1'b1;                                     // ST
      6'b010???: begin dec_src = 2'b10; dec_flag_wr = 1'b1; end     // ALU
      6'b01100?: begin dec_src = 2'b10; dec_flag_wr = 1'b1; end     // ASL/ASR
      6'b100000: dec_jmp = 1'b1;                                    // JMP
      6'b101???: begin
        // Conditions 110 and 111 are not defined.
        if (op[2:1] == 2'b11) dec_illegal = 1'b1;
        else                  dec_br      = 1'b1;
      end
      default:   dec_illegal = 1'b1;
    endcase
  end

  // idx_flags is {z,c,n}
  always_comb begin
    case (op[2:0])
      3'b000:  br_cond =  idx_flags[2];
      3'b001:  br_cond = !idx_flags[2];
      3'b010:  br_cond =  idx_flags[1];
      3'b011:  br_cond = !idx_flags[1];
      3'b100:  br_cond =  idx_flags[0];
      3'b101:  br_cond = !idx_flags[0];
      default: br_cond = 1'b0;
    endcase
  end

  assign dec_taken = dec_br && br_cond;

  for (genvar gi = 0; gi < ACC_N; gi++) begin : g_sel
    assign dec_acc_sel[2*gi +: 2] = (idx == AIW'(gi)) ? dec_src : 2'b00;
  end

  // ---------------------------------------------------------------------------
  // Handshake, hazard stall and flush
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [ACC_N-1:0] haz_nz;
  logic             drop_idle;
  logic             stall;
  logic             accept;
  logic             issue;
  logic             discard;
  logic             out_valid_q, out_valid_d;

  assign drop_idle = (drop_cnt_q == '0);
  // Instructions that are being flushed never stall. This lets a
  // discarded branch drain even if its flags are still pending.
  assign stall     = (op[5:3] == 3'b101) && in_valid && haz_nz[idx] && drop_idle;
  assign in_ready  = (!out_valid_q || out_ready) && !stall;
  assign accept    = in_valid && in_ready;
  assign issue     = accept && drop_idle;
  assign discard   = accept && !drop_idle;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (discard)
      drop_cnt_d = drop_cnt_q - 1'b1;
    else if (issue && (dec_jmp || dec_taken))
      drop_cnt_d = DW'(FLUSH_CYC);
  end

  // Per-accumulator flag hazard counters. A newly issued writer reloads
  // its counter, and that reload takes priority over the decrement.
  for (genvar gi = 0; gi < ACC_N; gi++) begin : g_haz
    logic [HW-1:0] haz_cnt_q, haz_cnt_d;

    always_comb begin
      if (issue && dec_flag_wr && (idx == AIW'(gi)))
        haz_cnt_d = HW'(HAZ_CYC);
      else if (haz_cnt_q != '0)
        haz_cnt_d = haz_cnt_q - 1'b1;
      else
        haz_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
      if (reset) haz_cnt_q <= '0;
      else       haz_cnt_q <= haz_cnt_d;
    end

    assign haz_nz[gi] = (haz_cnt_q != '0);
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [2*ACC_N-1:0] acc_sel_q, acc_sel_d;
  logic [AIW-1:0]     acc_idx_q, acc_idx_d;
  logic               wr_enable_q, wr_enable_d;
  logic               jmp_enable_q, jmp_enable_d;
  logic               branch_enable_q, branch_enable_d;
  logic               illegal_q, illegal_d;
  logic [5:0]         op_code_q, op_code_d;
  logic [7:0]         inm_q, inm_d;
  logic [OPW_LO-1:0]  mem_dir_q, mem_dir_d;
  logic [5:0]         branch_dir_q, branch_dir_d;
  logic [OPW_LO-1:0]  jmp_dir_q, jmp_dir_d;

  always_comb begin
    // By default, fields hold their values and a consumed beat retires.
    out_valid_d     = out_valid_q && !out_ready;
    acc_sel_d       = acc_sel_q;
    acc_idx_d       = acc_idx_q;
    wr_enable_d     = wr_enable_q;
    jmp_enable_d    = jmp_enable_q;
    branch_enable_d = branch_enable_q;
    illegal_d       = illegal_q;
    op_code_d       = op_code_q;
    inm_d           = inm_q;
    mem_dir_d       = mem_dir_q;
    branch_dir_d    = branch_dir_q;
    jmp_dir_d       = jmp_dir_q;
    if (issue) begin
      out_valid_d     = 1'b1;
      acc_sel_d       = dec_acc_sel;
      acc_idx_d       = idx;
      wr_enable_d     = dec_wr;
      jmp_enable_d    = dec_jmp;
      branch_enable_d = dec_taken;
      illegal_d       = dec_illegal;
      op_code_d       = op;
      inm_d           = in[7:0];
      mem_dir_d       = in[OPW_LO-1:0];
      branch_dir_d    = in[5:0];
      jmp_dir_d       = in[OPW_LO-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      drop_cnt_q      <= '0;
      acc_sel_q       <= '0;
      acc_idx_q       <= '0;
      wr_enable_q     <= 1'b0;
      jmp_enable_q    <= 1'b0;
      branch_enable_q <= 1'b0;
      illegal_q       <= 1'b0;
      op_code_q       <= '0;
      inm_q           <= '0;
      mem_dir_q       <= '0;
      branch_dir_q    <= '0;
      jmp_dir_q       <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      drop_cnt_q      <= drop_cnt_d;
      acc_sel_q       <= acc_sel_d;
      acc_idx_q       <= acc_idx_d;
      wr_enable_q     <= wr_enable_d;
      jmp_enable_q    <= jmp_enable_d;
      branch_enable_q <= branch_enable_d;
      illegal_q       <= illegal_d;
      op_code_q       <= op_code_d;
      inm_q           <= inm_d;
      mem_dir_q       <= mem_dir_d;
      branch_dir_q    <= branch_dir_d;
      jmp_dir_q       <= jmp_dir_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign acc_sel       = acc_sel_q;
  assign acc_idx       = acc_idx_q;
  assign wr_enable     = wr_enable_q;
  assign jmp_enable    = jmp_enable_q;
  assign branch_enable = branch_enable_q;
  assign illegal       = illegal_q;
  assign op_code       = op_code_q;
  assign inm           = inm_q;
  assign mem_dir       = mem_dir_q;
  assign branch_dir    = branch_dir_q;
  assign jmp_dir       = jmp_dir_q;

`ifdef DECODE_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_tot_q, drop_tot_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_tot_d  = drop_tot_q;
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (discard && (drop_tot_q != 16'hFFFF))
      drop_tot_d = drop_tot_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      drop_tot_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_tot_q  <= drop_tot_d;
    end
  end

  assign stall_cnt      = stall_cnt_q;
  assign drop_cnt_total = drop_tot_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage (IW=16, ACC_N=2, HAZ_CYC=2, FLUSH_CYC=1).
// Inputs change 1 time unit after the rising edge. Registered outputs are
// sampled at that same point. in_ready is sampled 1 time unit after the
// inputs change.

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_w;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  flags;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  acc_sel;
  logic [0:0]  acc_idx;
  logic        wr_enable;
  logic        jmp_enable;
  logic        branch_enable;
  logic        illegal;
  logic [5:0]  op_code;
  logic [7:0]  inm;
  logic [8:0]  mem_dir;
  logic [5:0]  branch_dir;
  logic [8:0]  jmp_dir;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] drop_cnt_total;
`endif

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in            (in_w),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flags         (flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .acc_sel       (acc_sel),
    .acc_idx       (acc_idx),
    .wr_enable     (wr_enable),
    .jmp_enable    (jmp_enable),
    .branch_enable (branch_enable),
    .illegal       (illegal),
    .op_code       (op_code),
    .inm           (inm),
    .mem_dir       (mem_dir),
    .branch_dir    (branch_dir),
    .jmp_dir       (jmp_dir)
`ifdef DECODE_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .drop_cnt_total(drop_cnt_total)
`endif
  );

  always #5 clk = ~clk;

  // Hand-encoded instructions: {op[5:0], idx, low[8:0]}
  localparam logic [15:0] I_LDC0 = 16'h2405;  // LDC acc0, imm 0x05
  localparam logic [15:0] I_ADD0 = 16'h4011;  // ADD acc0
  localparam logic [15:0] I_ST0  = 16'h2811;  // ST  acc0, addr 0x011
  localparam logic [15:0] I_ADD1 = 16'h4203;  // ADD acc1
  localparam logic [15:0] I_BEQ1 = 16'hA22A;  // BEQ acc1, dir 0x2A
  localparam logic [15:0] I_BNE1 = 16'hA607;  // BNE acc1, dir 0x07
  localparam logic [15:0] I_JMP  = 16'h83FF;  // JMP, low field 0x1FF
  localparam logic [15:0] I_ILL  = 16'hFC05;  // opcode 111111
  localparam logic [15:0] I_BEQ0 = 16'hA001;  // BEQ acc0, dir 0x01

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[%0t] FAIL %s: observed 0x%0h, expected 0x%0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s: 0x%0h", $time, tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] instr);
    in_w     = instr;
    in_valid = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    in_w      = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flags     = 6'b000000;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst out_valid", out_valid, 0);
    check("rst acc_sel", acc_sel, 0);
    check("rst illegal", illegal, 0);
    check("rst enables", {wr_enable, jmp_enable, branch_enable}, 0);
    check("rst inm", inm, 0);
    #1 check("rst in_ready", in_ready, 1);

    // LDC acc0: latency of one cycle, immediate source
    present(I_LDC0);
    tick();
    in_valid = 1'b0;
    check("ldc out_valid", out_valid, 1);
    check("ldc acc_sel", acc_sel, 4'b0001);
    check("ldc inm", inm, 8'h05);
    check("ldc op_code", op_code, 6'h09);
    check("ldc enables", {wr_enable, jmp_enable, branch_enable, illegal}, 0);
    tick();
    check("idle out_valid", out_valid, 0);

    // Backpressure: an ADD is held while out_ready=0 and the next beat waits
    out_ready = 1'b0;
    present(I_ADD0);
    tick();
    present(I_ST0);
    #1 check("bp in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold valid", out_valid, 1);
      check("bp hold op", op_code, 6'h10);
      check("bp hold sel", acc_sel, 4'b0010);
    end
    out_ready = 1'b1;
    #1 check("bp release ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("st out_valid", out_valid, 1);
    check("st wr_enable", wr_enable, 1);
    check("st mem_dir", mem_dir, 9'h011);
    check("st acc_sel", acc_sel, 0);
    tick();

    // Flag hazard: ADD acc1 followed immediately by BEQ acc1 with z1=1
    flags = 6'b100_000;
    present(I_ADD1);
    tick();
    check("add1 acc_sel", acc_sel, 4'b1000);
    check("add1 acc_idx", acc_idx, 1);
    present(I_BEQ1);
    #1 check("haz stall 1", in_ready, 0);
    tick();
    check("haz stall 2", in_ready, 0);
    tick();
    check("haz clear", in_ready, 1);
    tick();
    check("beq out_valid", out_valid, 1);
    check("beq taken", branch_enable, 1);
    check("beq branch_dir", branch_dir, 6'h2A);
    // A taken branch flushes one follower
    present(I_LDC0);
    tick();
    in_valid = 1'b0;
    check("beq flush drop", out_valid, 0);

    // Not-taken BNE with z1=1: no flush, follower issues
    present(I_BNE1);
    tick();
    check("bne out_valid", out_valid, 1);
    check("bne not taken", branch_enable, 0);
    check("bne op_code", op_code, 6'h29);
    present(I_ST0);
    tick();
    in_valid = 1'b0;
    check("bne follower issued", out_valid, 1);
    check("bne follower op", op_code, 6'h0A);
    tick();

    // JMP: first follower is dropped and the second follower is decoded
    present(I_JMP);
    tick();
    check("jmp enable", jmp_enable, 1);
    check("jmp dir", jmp_dir, 9'h1FF);
    check("jmp acc_sel", acc_sel, 0);
    present(I_ST0);
    tick();
    check("jmp drop follower1", out_valid, 0);
    present(I_LDC0);
    tick();
    in_valid = 1'b0;
    check("jmp follower2 valid", out_valid, 1);
    check("jmp follower2 op", op_code, 6'h09);
    check("jmp follower2 jmp", jmp_enable, 0);
    repeat (3) tick();

    // Illegal opcode: decoded as a NOP with no flush and no hazard load
    flags = 6'b000_000;
    present(I_ILL);
    tick();
    check("ill illegal", illegal, 1);
    check("ill enables", {wr_enable, jmp_enable, branch_enable}, 0);
    check("ill acc_sel", acc_sel, 0);
    check("ill out_valid", out_valid, 1);
    present(I_BEQ0);
    #1 check("ill no hazard", in_ready, 1);
    tick();
    check("ill no flush", out_valid, 1);
    check("ill next op", op_code, 6'h28);
    check("ill next illegal", illegal, 0);
    check("beq0 not taken", branch_enable, 0);

    // Reset while a branch is stalled
    present(I_LDC0);
    tick();
    present(I_BEQ0);
    #1 check("pre-rst stall", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst-stall out_valid", out_valid, 0);
    check("rst-stall acc_sel", acc_sel, 0);
    check("rst-stall in_ready", in_ready, 1);
    tick();
    check("rst-stall beq issued", out_valid, 1);
    check("rst-stall beq op", op_code, 6'h28);

    // Reset while a flush is pending
    present(I_JMP);
    tick();
    check("pre-rst jmp", jmp_enable, 1);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("rst-drop out_valid", out_valid, 0);
    check("rst-drop jmp_enable", jmp_enable, 0);
    present(I_BEQ0);
    #1 check("rst-drop in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("rst-drop beq not dropped", out_valid, 1);
    check("rst-drop beq op", op_code, 6'h28);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
